prco_seq: RTL and testbench

PRCO_SEQ -- requirements
Module: prco_seq

---
 rtl/prco_seq.sv | 140 ++++++++++++++
 tb/tb_prco_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/prco_seq.sv
// Multi-cycle instruction sequencer: one-hot phase FSM with program counter,
// retired-instruction counter and a memory-acknowledge watchdog.
module prco_seq #(
    parameter int unsigned     PC_W        = 16,
    parameter logic [PC_W-1:0] RESET_PC    = {PC_W{1'b0}},
    parameter int unsigned     CNT_W       = 32,
    parameter int unsigned     ACK_TIMEOUT = 15
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic             i_mem_ack,
    input  logic             i_ram_req,
    input  logic             i_reg_we,
    input  logic             i_halt,
    input  logic             i_branch,
    input  logic [PC_W-1:0]  i_branch_target,
    output logic [7:0]       q_state,
    output logic [PC_W-1:0]  q_pc,
    output logic             q_mem_req,
    output logic             q_mem_is_fetch,
    output logic             q_reg_we,
    output logic [CNT_W-1:0] q_retired,
    output logic             q_fault
);

    typedef enum logic [7:0] {
        ST_RESET  = 8'h01,
        ST_FETCH  = 8'h02,
        ST_DECODE = 8'h04,
        ST_READ   = 8'h08,
        ST_EXEC   = 8'h10,
        ST_RAM    = 8'h20,
        ST_WRITE  = 8'h40,
        ST_HALT   = 8'h80
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(ACK_TIMEOUT);

    state_t           state_r;
    logic [PC_W-1:0]  pc_r;
    logic [CNT_W-1:0] retired_r;
    logic             fault_r;
    logic [7:0]       wait_r;
    logic [7:0]       wait_inc_s;
    logic             timeout_s;
    logic [PC_W-1:0]  pc_next_s;

    // Watchdog and next-PC arithmetic shared by the memory-wait and EXEC phases
    always_comb begin
        wait_inc_s = wait_r + 8'd1;
        timeout_s  = (wait_inc_s == TIMEOUT_C);
        if (i_branch) begin
            pc_next_s = i_branch_target;
        end else begin
            pc_next_s = pc_r + PC_W'(1);
        end
    end

    // Sequencer state, PC, retire counter, watchdog and sticky fault
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r   <= ST_RESET;
            pc_r      <= RESET_PC;
            retired_r <= {CNT_W{1'b0}};
            fault_r   <= 1'b0;
            wait_r    <= 8'd0;
        end else if (i_en) begin
            case (state_r)
                ST_RESET: begin
                    state_r <= ST_FETCH;
                    wait_r  <= 8'd0;
                end
                ST_FETCH: begin
                    // An ack on the final permitted cycle still wins over the timeout
                    if (i_mem_ack) begin
                        state_r <= ST_DECODE;
                    end else if (timeout_s) begin
                        state_r <= ST_HALT;
                        fault_r <= 1'b1;
                    end else begin
                        wait_r <= wait_inc_s;
                    end
                end
                ST_DECODE: begin
                    state_r <= ST_READ;
                end
                ST_READ: begin
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (i_halt) begin
                        state_r <= ST_HALT;
                    end else if (i_ram_req) begin
                        state_r <= ST_RAM;
                        wait_r  <= 8'd0;
                        pc_r    <= pc_next_s;
                    end else begin
                        state_r <= ST_WRITE;
                        pc_r    <= pc_next_s;
                    end
                end
                ST_RAM: begin
                    if (i_mem_ack) begin
                        state_r <= ST_WRITE;
                    end else if (timeout_s) begin
                        state_r <= ST_HALT;
                        fault_r <= 1'b1;
                    end else begin
                        wait_r <= wait_inc_s;
                    end
                end
                ST_WRITE: begin
                    state_r   <= ST_FETCH;
                    wait_r    <= 8'd0;
                    retired_r <= retired_r + CNT_W'(1);
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    // Corrupted (non-one-hot) encoding recovers through RESET
                    state_r <= ST_RESET;
                    wait_r  <= 8'd0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign q_state        = state_r;
    assign q_pc           = pc_r;
    assign q_retired      = retired_r;
    assign q_fault        = fault_r;
    assign q_mem_req      = state_r[1] | state_r[5];
    assign q_mem_is_fetch = state_r[1];
    assign q_reg_we       = state_r[6] & i_reg_we & i_en;

endmodule

// File: tb/tb_prco_seq.sv
// Directed-vector bench for prco_seq with hand-computed expectations.
module tb_prco_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        ack;
    logic        ram_req;
    logic        reg_we;
    logic        halt;
    logic        branch;
    logic [15:0] target;
    logic [7:0]  q_state;
    logic [15:0] q_pc;
    logic        q_mem_req;
    logic        q_mem_is_fetch;
    logic        q_reg_we;
    logic [31:0] q_retired;
    logic        q_fault;

    int n_checks = 0;
    int n_pass   = 0;

    prco_seq #(
        .PC_W(16), .RESET_PC(16'h0000), .CNT_W(32), .ACK_TIMEOUT(4)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_mem_ack(ack),
        .i_ram_req(ram_req), .i_reg_we(reg_we), .i_halt(halt), .i_branch(branch),
        .i_branch_target(target), .q_state(q_state), .q_pc(q_pc),
        .q_mem_req(q_mem_req), .q_mem_is_fetch(q_mem_is_fetch), .q_reg_we(q_reg_we),
        .q_retired(q_retired), .q_fault(q_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH with an immediate ack, advance through DECODE and READ into EXEC
    task automatic go_exec(input string tag);
        ack = 1'b1;
        repeat (3) step();
        chk(tag, q_state, 8'h10);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_state"}, q_state, 8'h01);
        chk({tag, "_pc"}, q_pc, 16'h0000);
        chk({tag, "_ret"}, q_retired, 32'd0);
        chk({tag, "_fault"}, q_fault, 1'b0);
        #1 rst_n = 1'b1;
        halt = 1'b0; branch = 1'b0; ram_req = 1'b0; reg_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; ack = 1'b0; ram_req = 1'b0; reg_we = 1'b0;
        halt = 1'b0; branch = 1'b0; target = 16'h0000;
        #12;
        chk("rst_state", q_state, 8'h01);
        chk("rst_pc", q_pc, 16'h0000);
        chk("rst_ret", q_retired, 32'd0);
        chk("rst_fault", q_fault, 1'b0);
        chk("rst_memreq", q_mem_req, 1'b0);
        #1 rst_n = 1'b1; en = 1'b1; ack = 1'b1;

        // basic instruction: no RAM, no branch
        step(); chk("t1_fetch", q_state, 8'h02);
        chk("t1_memreq", q_mem_req, 1'b1);
        chk("t1_isfetch", q_mem_is_fetch, 1'b1);
        step(); chk("t1_decode", q_state, 8'h04);
        step(); chk("t1_read", q_state, 8'h08);
        step(); chk("t1_exec", q_state, 8'h10);
        step(); chk("t1_write", q_state, 8'h40);
        chk("t1_pc", q_pc, 16'h0001);
        chk("t1_regwe0", q_reg_we, 1'b0);
        step(); chk("t1_fetch2", q_state, 8'h02);
        chk("t1_ret", q_retired, 32'd1);

        // RAM phase with ack delayed to third cycle
        go_exec("t2_exec");
        ram_req = 1'b1; reg_we = 1'b1; ack = 1'b0;
        step(); chk("t2_ram", q_state, 8'h20);
        chk("t2_pc", q_pc, 16'h0002);
        chk("t2_isfetch", q_mem_is_fetch, 1'b0);
        chk("t2_memreq", q_mem_req, 1'b1);
        step(); chk("t2_ram1", q_state, 8'h20);
        step(); chk("t2_ram2", q_state, 8'h20);
        ack = 1'b1;
        step(); chk("t2_write", q_state, 8'h40);
        chk("t2_regwe", q_reg_we, 1'b1);
        ram_req = 1'b0;
        step(); chk("t2_fetch", q_state, 8'h02);
        chk("t2_regwe_off", q_reg_we, 1'b0);
        chk("t2_ret", q_retired, 32'd2);
        reg_we = 1'b0;

        // branches and PC wrap
        go_exec("t3_exec_a");
        branch = 1'b1; target = 16'h0040;
        step(); chk("t3_pc40", q_pc, 16'h0040);
        step(); chk("t3_fetch_pc", q_pc, 16'h0040);
        chk("t3_ret", q_retired, 32'd3);
        go_exec("t3_exec_b");
        target = 16'hFFFF;
        step(); step(); chk("t3_pcffff", q_pc, 16'hFFFF);
        go_exec("t3_exec_c");
        branch = 1'b0;
        step(); chk("t3_wrap", q_pc, 16'h0000);
        step(); chk("t3_ret5", q_retired, 32'd5);

        // ack arrives on the last permitted fetch cycle
        ack = 1'b0;
        repeat (3) step();
        chk("t4_wait", q_state, 8'h02);
        ack = 1'b1;
        step(); chk("t4_decode", q_state, 8'h04);
        chk("t4_nofault", q_fault, 1'b0);
        step(); step(); chk("t4_exec", q_state, 8'h10);
        step(); step(); chk("t4_ret", q_retired, 32'd6);
        chk("t4_pc", q_pc, 16'h0001);

        // halt has priority over branch and RAM; HALT absorbs
        go_exec("t5_exec");
        halt = 1'b1; branch = 1'b1; target = 16'h1234; ram_req = 1'b1;
        step(); chk("t5_halt", q_state, 8'h80);
        chk("t5_pc", q_pc, 16'h0001);
        ack = 1'b1; en = 1'b0; step();
        en = 1'b1; step(); step();
        ack = 1'b0; step();
        chk("t5_stay", q_state, 8'h80);
        chk("t5_pc_stay", q_pc, 16'h0001);
        chk("t5_ret", q_retired, 32'd6);
        chk("t5_memreq", q_mem_req, 1'b0);
        pulse_reset("r1");

        // fetch timeout
        ack = 1'b0;
        step(); chk("t6_fetch", q_state, 8'h02);
        repeat (3) step();
        chk("t6_pre", q_state, 8'h02);
        chk("t6_pre_fault", q_fault, 1'b0);
        step(); chk("t6_halt", q_state, 8'h80);
        chk("t6_fault", q_fault, 1'b1);
        ack = 1'b1; step();
        chk("t6_sticky", q_fault, 1'b1);
        pulse_reset("r2");

        // stall mid-RAM, then asynchronous reset
        ack = 1'b1;
        step(); go_exec("t7_exec");
        ram_req = 1'b1; reg_we = 1'b1; ack = 1'b0;
        step(); chk("t7_ram", q_state, 8'h20);
        step();
        en = 1'b0; ack = 1'b1;
        repeat (5) step();
        chk("t7_frz_state", q_state, 8'h20);
        chk("t7_frz_pc", q_pc, 16'h0001);
        chk("t7_frz_memreq", q_mem_req, 1'b1);
        chk("t7_frz_regwe", q_reg_we, 1'b0);
        en = 1'b1; ack = 1'b0;
        step(); step();
        chk("t7_cnt_held", q_state, 8'h20);
        chk("t7_nofault", q_fault, 1'b0);
        pulse_reset("r3");
        step(); chk("t7_restart", q_state, 8'h02);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
